rc5_cipher_core: RTL and testbench
==================================

Name: rc5_cipher_core

Overview:
Iterative RC5-w/r block cipher core that performs both encryption and decryption, processing one full round per clock.
Generalises the fixed 32-bit, 12-round encrypt datapath:
- word width and round count are parameters;
- the expanded key table S[] is loadable at run time;
- encrypt or decrypt is selected per block;
- valid/ready handshakes on input and output.

It sits between the input framing module and the output module of the cipher top level.

Parameters:
W, 32, word width in bits (16, 32 or 64); block = 2*W bits.
ROUNDS, 12, number of rounds r (1..255).
T, 2*ROUNDS+2, S-table depth (derived; do not override).
LGW, $clog2(W), number of rotate-amount bits taken from a word.

Ports:
clk  in  1  rising-edge clock.
clr  in  1  synchronous active-low reset.
key_we  in  1  S-table write strobe.
key_addr  in  8  S-table index.
key_wdata  in  W  S-table word.
mode  in  1  0 = encrypt, 1 = decrypt; sampled at input accept.
din  in  2W  input block {A,B}; A = din[2W-1:W].
di_vld  in  1  input block valid.
di_rdy  out  1  core can accept a block.
dout  out  2W  result block {A,B}.
do_vld  out  1  result valid.
do_rdy  in  1  downstream accepts result.
blk_cnt  out  32  completed-block counter (see Optional Feature).

Behaviour:
- Reset (clr=0 at an edge):
  - state IDLE, di_rdy=1, do_vld=0, dout=0, blk_cnt=0, round counter=0;
  - all S entries cleared to 0;
  - reset mid-operation aborts the block with no output.
- States: IDLE -> PRE -> ROUND -> DONE -> IDLE.
  - IDLE: di_rdy=1. On di_vld & di_rdy, latch din into A,B and latch mode; go to PRE.
  - PRE, encrypt: A=A+S[0], B=B+S[1].
  - PRE, decrypt: i=ROUNDS; no arithmetic. Go to ROUND.
  - ROUND, encrypt, i=1..ROUNDS:
    - A=((A^B)<<<B[LGW-1:0])+S[2i];
    - B=((B^A_new)<<<A_new[LGW-1:0])+S[2i+1].
  - ROUND, decrypt, i=ROUNDS..1:
    - B=((B-S[2i+1])>>>A[LGW-1:0])^A;
    - A=((A-S[2i])>>>B_new[LGW-1:0])^B_new;
    - on the final iteration also apply B=B-S[1], A=A-S[0] in the same cycle.
  - After ROUNDS round cycles, load dout={A,B}, set do_vld=1, go to DONE.
  - DONE: hold dout and do_vld until do_rdy=1. Then do_vld=0, state IDLE, di_rdy=1 on the next cycle.
- Latency: accept edge t0 -> do_vld high after edge t0+ROUNDS+1.
  - Throughput: one block per ROUNDS+3 cycles when do_rdy is held high.
- Arithmetic: all add/sub is modulo 2^W, with no carry out.
  - A rotate amount of 0 is the identity; there is no shift by W.
- di_rdy=0 in PRE, ROUND and DONE; di_vld is ignored there.
- Key writes:
  - accepted only in IDLE with key_addr<T;
  - ignored otherwise, with no error signalled;
  - a write coincident with an input accept takes effect before PRE reads S.
- mode changes after accept do not affect the in-flight block.
- dout retains the last result after DONE.

Optional Feature:
RC5_BLOCK_CNT_EN
- Defined: blk_cnt increments by 1 at each output handshake (do_vld & do_rdy), wraps 0xFFFFFFFF -> 0, and is cleared by reset.
- Undefined: blk_cnt is tied to 0 and no counter register is built.

Decomposition:
- Package rc5_pkg holds:
  - state enum (IDLE, PRE, ROUND, DONE);
  - mode constants ENC=0, DEC=1;
  - parameterised rotl/rotr functions.
- One sub-module, rc5_round: combinational full round for both modes. Inputs A, B, S[2i], S[2i+1], mode; outputs A', B'.
- The core keeps the FSM, S-table, counters and handshakes.

Test Plan:
1. W=32, ROUNDS=2, S all 0 (after reset), encrypt din=0x00000001_00000000 -> dout=0x0000000C_0000E000, do_vld after 3 edges.
2. Same S, decrypt din=0x0000000C_0000E000 -> dout=0x00000001_00000000.
3. ROUNDS=12, load S[0..25] with 0x9BBBD8C8, 0x1A37F7FB, ...; encrypt then decrypt 100 random blocks -> each decrypt output equals the original plaintext.
4. Backpressure: do_rdy=0 for 5 cycles after do_vld -> dout/do_vld stable, di_rdy=0 throughout; a di_vld pulse meanwhile is not accepted.
5. Key write while busy (addr 0, data 0xFFFFFFFF in ROUND) -> ignored; key_addr=T in IDLE -> ignored; both cases give a result identical to the golden model.
6. clr=0 mid-ROUND -> next edge di_rdy=1, do_vld=0, blk_cnt=0; with RC5_BLOCK_CNT_EN, 3 completed blocks -> blk_cnt=3.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared types and helpers for the RC5-w/r cipher core: FSM states, mode codes, word rotates.
// Rotates use a 64-bit container so a single pair of functions serves every word width.
package rc5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    // x must already be zero above bit w-1; an amount of 0 returns x unchanged.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int amt, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x << amt) | (x >> (w - amt))) & mask;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int amt, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x >> amt) | (x << (w - amt))) & mask;
    endfunction

endpackage

// File: rtl/rc5_round.sv
// One full RC5 round, purely combinational, for encrypt (mode=ENC) or decrypt (mode=DEC).
module rc5_round
    import rc5_pkg::*;
#(
    parameter int W   = 32,
    parameter int LGW = $clog2(W)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_even,
    input  logic [W-1:0] s_odd,
    input  logic         mode,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);

    logic [63:0]  rot_a;
    logic [63:0]  rot_b;
    logic [W-1:0] diff_a;
    logic [W-1:0] diff_b;

    always_comb begin
        a_out  = '0;
        b_out  = '0;
        rot_a  = '0;
        rot_b  = '0;
        diff_a = a - s_even;
        diff_b = b - s_odd;
        if (mode == ENC) begin
            rot_a = rotl(64'(a ^ b), int'(b[LGW-1:0]), W);
            a_out = rot_a[W-1:0] + s_even;
            rot_b = rotl(64'(b ^ a_out), int'(a_out[LGW-1:0]), W);
            b_out = rot_b[W-1:0] + s_odd;
        end else begin
            // Decrypt undoes B first, then uses the recovered B to undo A.
            rot_b = rotr(64'(diff_b), int'(a[LGW-1:0]), W);
            b_out = rot_b[W-1:0] ^ a;
            rot_a = rotr(64'(diff_a), int'(b_out[LGW-1:0]), W);
            a_out = rot_a[W-1:0] ^ b_out;
        end
    end

endmodule

// File: rtl/rc5_cipher_core.sv
// Iterative RC5-w/r encrypt/decrypt core, one round per clock, with run-time loadable S table.
// Define RC5_BLOCK_CNT_EN to build the completed-block counter on blk_cnt.
module rc5_cipher_core
    import rc5_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = 12,
    parameter int T      = 2*ROUNDS+2,
    parameter int LGW    = $clog2(W)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           key_we,
    input  logic [7:0]     key_addr,
    input  logic [W-1:0]   key_wdata,
    input  logic           mode,
    input  logic [2*W-1:0] din,
    input  logic           di_vld,
    output logic           di_rdy,
    output logic [2*W-1:0] dout,
    output logic           do_vld,
    input  logic           do_rdy,
    output logic [31:0]    blk_cnt
);

    localparam int IW = $clog2(T);
    localparam int RW = $clog2(ROUNDS+1);

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, b_reg;
    logic           mode_reg;
    logic [RW-1:0]  rnd_reg;
    logic [2*W-1:0] dout_reg;
    logic [W-1:0]   s_reg [T];

    logic [IW-1:0]  key_idx, idx_even, idx_odd;
    logic           key_ok, last_round;
    logic [W-1:0]   a_rnd, b_rnd, a_fin, b_fin;

    assign key_idx  = IW'(key_addr);
    assign key_ok   = (state_reg == IDLE) && key_we && ({24'd0, key_addr} < T);
    assign idx_even = IW'({rnd_reg, 1'b0});
    assign idx_odd  = IW'({rnd_reg, 1'b1});
    assign last_round = (mode_reg == ENC) ? (rnd_reg == RW'(ROUNDS)) : (rnd_reg == RW'(1));

    rc5_round #(.W(W), .LGW(LGW)) u_round (
        .a      (a_reg),
        .b      (b_reg),
        .s_even (s_reg[idx_even]),
        .s_odd  (s_reg[idx_odd]),
        .mode   (mode_reg),
        .a_out  (a_rnd),
        .b_out  (b_rnd)
    );

    // The decrypt post-whitening folds into the last round cycle.
    assign a_fin = (mode_reg == DEC && last_round) ? a_rnd - s_reg[0] : a_rnd;
    assign b_fin = (mode_reg == DEC && last_round) ? b_rnd - s_reg[1] : b_rnd;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (di_vld) state_next = PRE;
            PRE:     state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE:    if (do_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= ENC;
            rnd_reg   <= '0;
            dout_reg  <= '0;
            for (int k = 0; k < T; k++) s_reg[k] <= '0;
        end else begin
            state_reg <= state_next;
            if (key_ok) s_reg[key_idx] <= key_wdata;
            case (state_reg)
                IDLE: begin
                    if (di_vld) begin
                        a_reg    <= din[2*W-1:W];
                        b_reg    <= din[W-1:0];
                        mode_reg <= mode;
                    end
                end
                PRE: begin
                    if (mode_reg == ENC) begin
                        a_reg   <= a_reg + s_reg[0];
                        b_reg   <= b_reg + s_reg[1];
                        rnd_reg <= RW'(1);
                    end else begin
                        rnd_reg <= RW'(ROUNDS);
                    end
                end
                ROUND: begin
                    a_reg   <= a_fin;
                    b_reg   <= b_fin;
                    rnd_reg <= (mode_reg == ENC) ? rnd_reg + RW'(1) : rnd_reg - RW'(1);
                    if (last_round) dout_reg <= {a_fin, b_fin};
                end
                default: ;
            endcase
        end
    end

    assign di_rdy = (state_reg == IDLE);
    assign do_vld = (state_reg == DONE);
    assign dout   = dout_reg;

`ifdef RC5_BLOCK_CNT_EN
    logic [31:0] blk_cnt_reg;
    always_ff @(posedge clk) begin
        if (!clr)                 blk_cnt_reg <= '0;
        else if (do_vld && do_rdy) blk_cnt_reg <= blk_cnt_reg + 32'd1;
    end
    assign blk_cnt = blk_cnt_reg;
`else
    assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_rc5_cipher_core.sv
// Scoreboard bench for rc5_cipher_core (W=32, ROUNDS=12): RC5 reference model, round-trip checks,
// backpressure, ignored key writes and mid-block reset.
module tb_rc5_cipher_core;

    localparam int R  = 12;
    localparam int TT = 2*R+2;

    logic        clk = 1'b0;
    logic        clr;
    logic        key_we;
    logic [7:0]  key_addr;
    logic [31:0] key_wdata;
    logic        mode;
    logic [63:0] din;
    logic        di_vld;
    logic        di_rdy;
    logic [63:0] dout;
    logic        do_vld;
    logic        do_rdy;
    logic [31:0] blk_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;
    logic [31:0] s_m [TT];

    always #5 clk = ~clk;

    rc5_cipher_core #(.W(32), .ROUNDS(R)) dut (
        .clk(clk), .clr(clr), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
        .mode(mode), .din(din), .di_vld(di_vld), .di_rdy(di_rdy), .dout(dout),
        .do_vld(do_vld), .do_rdy(do_rdy), .blk_cnt(blk_cnt)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endfunction

    // Textbook RC5-32/12 encryption and decryption over the model S table.
    function automatic logic [63:0] model(input logic m, input logic [63:0] blk);
        logic [31:0] a, b;
        a = blk[63:32];
        b = blk[31:0];
        if (m == 1'b0) begin
            a = a + s_m[0];
            b = b + s_m[1];
            for (int i = 1; i <= R; i++) begin
                a = rl(a ^ b, int'(b % 32)) + s_m[2*i];
                b = rl(b ^ a, int'(a % 32)) + s_m[2*i+1];
            end
        end else begin
            for (int i = R; i >= 1; i--) begin
                b = rr(b - s_m[2*i+1], int'(a % 32)) ^ a;
                a = rr(a - s_m[2*i], int'(b % 32)) ^ b;
            end
            b = b - s_m[1];
            a = a - s_m[0];
        end
        return {a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: an output handshake completes at the next edge when both are high now.
    always @(negedge clk) begin
        if (clr && do_vld && do_rdy) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", dout);
            end else begin
                last_exp = exp_q.pop_front();
                chk("dout", dout, last_exp);
            end
        end
    end

    task automatic write_key(input logic [7:0] addr, input logic [31:0] data);
        key_we = 1'b1; key_addr = addr; key_wdata = data;
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic send(input logic m, input logic [63:0] blk, input logic [63:0] exp);
        int n = 0;
        while (!di_rdy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("di_rdy_timeout", {63'd0, di_rdy}, 64'd1);
        exp_q.push_back(exp);
        mode = m; din = blk; di_vld = 1'b1;
        @(posedge clk); #1;
        di_vld = 1'b0;
        mode = 1'($urandom);
        din = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic cnt_check(input string name);
`ifdef RC5_BLOCK_CNT_EN
        chk(name, 64'(blk_cnt), 64'(hs_cnt));
`else
        chk(name, 64'(blk_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic [63:0] pt, ct, cap;
        int n;
        clr = 1'b0; key_we = 1'b0; key_addr = '0; key_wdata = '0;
        mode = 1'b0; din = '0; di_vld = 1'b0; do_rdy = 1'b1;
        for (int k = 0; k < TT; k++) s_m[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_di_rdy", {63'd0, di_rdy}, 64'd1);
        chk("rst_do_vld", {63'd0, do_vld}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        // All-zero S table: encrypt and decrypt plus accept-to-valid latency.
        pt = 64'h00000001_00000000;
        ct = model(1'b0, pt);
        send(1'b0, pt, ct);
        n = 0;
        while (!do_vld && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(R+1));
        drain();
        send(1'b1, ct, pt);
        drain();

        // Random key table, then round trips and random decrypts.
        write_key(8'd0, 32'h9BBBD8C8); s_m[0] = 32'h9BBBD8C8;
        write_key(8'd1, 32'h1A37F7FB); s_m[1] = 32'h1A37F7FB;
        for (int k = 2; k < TT; k++) begin
            logic [31:0] v;
            v = $urandom;
            write_key(8'(k), v);
            s_m[k] = v;
        end
        for (int t = 0; t < 100; t++) begin
            pt = {$urandom, $urandom};
            ct = model(1'b0, pt);
            send(1'b0, pt, ct);
            send(1'b1, ct, pt);
            if (t % 10 == 0) begin
                ct = {$urandom, $urandom};
                send(1'b1, ct, model(1'b1, ct));
            end
        end
        drain();
        cnt_check("blk_cnt_run");

        // Backpressure: result must hold and a stray input must not be taken.
        do_rdy = 1'b0;
        pt = {$urandom, $urandom};
        send(1'b0, pt, model(1'b0, pt));
        n = 0;
        while (!do_vld && n < 50) begin
            @(posedge clk); #1; n++;
        end
        cap = dout;
        chk("bp_dout_value", cap, model(1'b0, pt));
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin di_vld = 1'b1; din = {$urandom, $urandom}; end
            if (c == 3) di_vld = 1'b0;
            @(posedge clk); #1;
            chk("bp_do_vld", {63'd0, do_vld}, 64'd1);
            chk("bp_dout", dout, cap);
            chk("bp_di_rdy", {63'd0, di_rdy}, 64'd0);
        end
        di_vld = 1'b0;
        do_rdy = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("bp_no_ghost", {63'd0, do_vld}, 64'd0);
        chk("dout_retained", dout, last_exp);

        // Key writes while busy and with an out-of-range index are ignored.
        pt = {$urandom, $urandom};
        send(1'b0, pt, model(1'b0, pt));
        @(posedge clk); #1;
        write_key(8'd0, 32'hFFFFFFFF);
        drain();
        write_key(8'(TT), $urandom);
        pt = {$urandom, $urandom};
        send(1'b0, pt, model(1'b0, pt));
        send(1'b1, pt, model(1'b1, pt));
        drain();

        // Reset in the middle of a block aborts it and clears the table.
        pt = {$urandom, $urandom};
        send(1'b0, pt, model(1'b0, pt));
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        hs_cnt = 0;
        for (int k = 0; k < TT; k++) s_m[k] = '0;
        chk("abort_di_rdy", {63'd0, di_rdy}, 64'd1);
        chk("abort_do_vld", {63'd0, do_vld}, 64'd0);
        chk("abort_blk_cnt", 64'(blk_cnt), 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            pt = {$urandom, $urandom};
            send(1'b0, pt, model(1'b0, pt));
        end
        drain();
        cnt_check("blk_cnt_after_3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
